// File: rtl/pipeline_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush and a
// saturating stall counter. Every output to either neighbour comes straight from a flop.
module pipeline_skid_stage #(
  parameter int unsigned              DATA_W  = 32,
  parameter logic        [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned              CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_main, w_main_d;
  logic [DATA_W-1:0] r_skid, w_skid_d;
  logic              r_in_ready, r_out_valid;
  logic [1:0]        r_occ, w_occ_d;
  logic [CNT_W-1:0]  r_stall_cnt, w_stall_cnt_d;
  logic              w_in_fire, w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    if (flush) begin
      w_state_d = StEmpty;
      w_main_d  = RST_VAL;
      w_skid_d  = RST_VAL;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_d = StOne;
            w_main_d  = in_data;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_d = in_data;
          end else if (w_in_fire) begin
            w_state_d = StFull;
            w_skid_d  = in_data;
          end else if (w_out_fire) begin
            // Main keeps the departed bundle; out_valid masks it.
            w_state_d = StEmpty;
          end
        end
        StFull: begin
          if (w_out_fire) begin
            w_state_d = StOne;
            w_main_d  = r_skid;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    w_occ_d = 2'd0;
    unique case (w_state_d)
      StOne:   w_occ_d = 2'd1;
      StFull:  w_occ_d = 2'd2;
      default: w_occ_d = 2'd0;
    endcase
  end

  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (stall_clr) begin
      w_stall_cnt_d = '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
    end
  end

  // Handshake flags are registered from the next state so nothing crosses stages combinationally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= StEmpty;
      r_main      <= RST_VAL;
      r_skid      <= RST_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_main      <= w_main_d;
      r_skid      <= w_skid_d;
      r_in_ready  <= (w_state_d != StFull);
      r_out_valid <= (w_state_d != StEmpty);
      r_occ       <= w_occ_d;
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;
  assign stall_cnt = r_stall_cnt;

endmodule
